// File: rtl/team_06_spi_rx.sv
// team_06_spi_rx
// SPI receive deserializer for the team_06 audio path. It samples sdi on the
// rising edge of sclk while cs is high and assembles bits MSB-first into
// bytes. Completed bytes go into a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst    system clock; asynchronous active-high reset
//   sclk        SPI clock, asynchronous to clk
//   cs          frame enable, active-high, asynchronous
//   sdi         serial data, must be stable around the sclk rising edge
//   out_data    FIFO head byte (mem[rptr]); meaningful only while out_valid
//   out_valid   FIFO holds at least one byte
//   out_ready   consumer accepts the head byte
//   fifo_count  number of bytes held in the FIFO
//   overflow    sticky: a completed byte was dropped because the FIFO was full
//   frame_err   sticky: cs fell part-way through a byte
//   clr_err     synchronous pulse; clears both sticky flags
//
// Handshake: a byte leaves the FIFO on every clk edge where
// out_valid && out_ready. out_data is stable while out_valid is high and no
// pop occurs. The next head byte is visible the cycle after a pop.
module team_06_spi_rx #(
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sclk,
    input  logic                     cs,
    input  logic                     sdi,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     frame_err,
    input  logic                     clr_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // ------------------------------------------------------------------
    // Synchronizers. All three inputs pass through chains of equal depth,
    // so they stay aligned with each other after synchronization.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            sdi_sync  <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
        end
    end

    logic sclk_s;
    logic cs_s;
    logic sdi_s;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Bit assembly
    // ------------------------------------------------------------------
    logic       sclk_q;
    logic       cs_q;
    logic [2:0] bcnt;
    // Only the seven most recent bits are stored. The eighth bit of a byte
    // goes straight from sdi_s into the FIFO on the completing rise.
    logic [6:0] sh;

    logic       rise;
    logic       cs_fall;
    logic       push;
    logic [7:0] push_byte;
    logic       frame_set;

    assign rise      = sclk_s && !sclk_q;
    assign cs_fall   = cs_q && !cs_s;
    assign push      = rise && cs_s && (bcnt == 3'd7);
    assign push_byte = {sh, sdi_s};
    // bcnt still holds its pre-fall value in the first cycle that cs_s is low.
    assign frame_set = cs_fall && (bcnt != 3'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q <= 1'b0;
            cs_q   <= 1'b0;
            bcnt   <= 3'd0;
            sh     <= 7'd0;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
            if (!cs_s) begin
                // Idle or end of frame: any partial byte is discarded.
                bcnt <= 3'd0;
            end else if (rise) begin
                sh   <= {sh[5:0], sdi_s};
                bcnt <= bcnt + 3'd1;  // wraps to 0 after the eighth bit
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          full;
    logic          pop;
    logic          wr_en;
    logic          ovf_set;

    assign full    = (fifo_count == CW'(DEPTH));
    assign pop     = out_valid && out_ready;
    // When the FIFO is full, a same-cycle pop frees the slot the push needs.
    assign wr_en   = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    assign out_valid = (fifo_count != '0);
    assign out_data  = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'd0;
            end
            wptr       <= '0;
            rptr       <= '0;
            fifo_count <= '0;
        end else begin
            if (wr_en) begin
                mem[wptr] <= push_byte;
                wptr      <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            case ({wr_en, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags. A clear wins over a set in the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (clr_err) begin
                overflow <= 1'b0;
            end else if (ovf_set) begin
                overflow <= 1'b1;
            end

            if (clr_err) begin
                frame_err <= 1'b0;
            end else if (frame_set) begin
                frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_team_06_spi_rx.sv
`timescale 1ns/1ps
module tb_team_06_spi_rx;

    localparam int DEPTH = 4;
    localparam int HALF  = 24;  // sclk half period in clk cycles (sclk = clk/48)

    logic       clk;
    logic       rst;
    logic       sclk;
    logic       cs;
    logic       sdi;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       frame_err;
    logic       clr_err;

    team_06_spi_rx #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .cs         (cs),
        .sdi        (sdi),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr_err    (clr_err)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    logic [7:0] exp_q[$];
    logic       exp_ovf;
    logic       exp_ferr;
    int         n_checks;
    int         n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // A completed byte enters the FIFO if there is room, otherwise it is lost.
    function automatic void model_push(input logic [7:0] b);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf = 1'b1;
    endfunction

    // ---------------- driver tasks (inputs change on negedge clk) ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sdi = b;
        wait_clk(HALF);
        sclk = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
    endtask

    // Sends the n most significant bits of val, MSB first.
    task automatic send_bits(input logic [7:0] val, input int n);
        for (int i = 0; i < n; i++) send_bit(val[7-i]);
    endtask

    task automatic start_frame();
        cs = 1'b1;
        wait_clk(8);
    endtask

    task automatic end_frame();
        cs = 1'b0;
        wait_clk(8);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        wait_clk(1);
        clr_err = 1'b0;
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    // Back-to-back pops of everything the model expects, checking each head.
    task automatic drain(input string tag);
        int idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            check($sformatf("%s_valid%0d", tag, idx), 32'(out_valid), 32'd1);
            check($sformatf("%s_data%0d", tag, idx), 32'(out_data), 32'(exp_q.pop_front()));
            out_ready = 1'b1;
            wait_clk(1);
            idx++;
        end
        out_ready = 1'b0;
        check({tag, "_empty_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_empty_count"}, 32'(fifo_count), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        logic [7:0] b;
        n_checks  = 0;
        n_pass    = 0;
        exp_ovf   = 1'b0;
        exp_ferr  = 1'b0;
        rst       = 1'b1;
        sclk      = 1'b0;
        cs        = 1'b0;
        sdi       = 1'b0;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        wait_clk(3);
        check("rst_data",  32'(out_data),   32'd0);
        check("rst_valid", 32'(out_valid),  32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ovf",   32'(overflow),   32'd0);
        check("rst_ferr",  32'(frame_err),  32'd0);
        rst = 1'b0;
        wait_clk(4);

        // Single byte 0xA5 with latency measurement on the 8th rise.
        start_frame();
        send_bits(8'hA5, 7);
        sdi = 1'b1;
        wait_clk(HALF);
        sclk = 1'b1;
        lat = 0;
        while (!out_valid && lat < 8) begin
            wait_clk(1);
            lat++;
        end
        check("single_latency_ok", 32'(lat >= 3 && lat <= 4), 32'd1);
        wait_clk(HALF - lat);
        sclk = 1'b0;
        end_frame();
        model_push(8'hA5);
        check("single_count", 32'(fifo_count), 32'd1);
        check("single_data",  32'(out_data),   32'hA5);
        drain("single");

        // Overflow: five bytes into a four-deep FIFO with no consumer.
        start_frame();
        for (int i = 1; i <= 5; i++) begin
            send_bits(8'(i), 8);
            model_push(8'(i));
        end
        end_frame();
        check("ovf_count", 32'(fifo_count), 32'(exp_q.size()));
        check("ovf_flag",  32'(overflow),   32'(exp_ovf));
        drain("ovf");
        pulse_clr();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Framing error: cs drops after five bits.
        start_frame();
        send_bits(8'hFF, 5);
        end_frame();
        exp_ferr = 1'b1;
        check("ferr_flag",  32'(frame_err),  32'd1);
        check("ferr_count", 32'(fifo_count), 32'd0);
        start_frame();
        send_bits(8'h3C, 8);
        end_frame();
        model_push(8'h3C);
        check("ferr_data",   32'(out_data),  32'h3C);
        check("ferr_sticky", 32'(frame_err), 32'(exp_ferr));
        drain("ferr");
        pulse_clr();
        check("ferr_cleared", 32'(frame_err), 32'd0);

        // Push and pop on the same edge while full. The 8th rise reaches the
        // FIFO on the third clk edge after the pin change; out_ready is high
        // only across that edge.
        start_frame();
        for (int i = 0; i < 4; i++) begin
            send_bits(8'h11 + 8'(i), 8);
            model_push(8'h11 + 8'(i));
        end
        send_bits(8'h15, 7);
        sdi = 1'b1;
        wait_clk(HALF);
        sclk = 1'b1;
        wait_clk(2);
        out_ready = 1'b1;
        wait_clk(1);
        out_ready = 1'b0;
        void'(exp_q.pop_front());
        model_push(8'h15);
        wait_clk(HALF - 3);
        sclk = 1'b0;
        end_frame();
        check("pp_ovf",   32'(overflow),   32'(exp_ovf));
        check("pp_count", 32'(fifo_count), 32'(exp_q.size()));
        drain("pp");

        // Reset mid-byte with a byte already queued.
        start_frame();
        send_bits(8'h77, 8);
        send_bits(8'hFF, 4);
        rst = 1'b1;
        #1;
        check("rst_mid_data",  32'(out_data),   32'd0);
        check("rst_mid_valid", 32'(out_valid),  32'd0);
        check("rst_mid_count", 32'(fifo_count), 32'd0);
        check("rst_mid_ovf",   32'(overflow),   32'd0);
        check("rst_mid_ferr",  32'(frame_err),  32'd0);
        exp_q.delete();
        cs = 1'b0;
        sclk = 1'b0;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(4);
        start_frame();
        send_bits(8'h81, 8);
        end_frame();
        model_push(8'h81);
        check("rst_after_count", 32'(fifo_count), 32'd1);
        check("rst_after_ferr",  32'(frame_err),  32'd0);
        drain("rst_after");

        // sclk activity with cs low is ignored.
        for (int i = 0; i < 16; i++) send_bit(1'($urandom_range(0, 1)));
        wait_clk(8);
        check("cslow_valid", 32'(out_valid),  32'd0);
        check("cslow_count", 32'(fifo_count), 32'd0);
        check("cslow_ovf",   32'(overflow),   32'd0);
        check("cslow_ferr",  32'(frame_err),  32'd0);

        // Random frames: random byte count, optional trailing partial byte.
        for (int it = 0; it < 10; it++) begin
            int nbytes;
            int pbits;
            nbytes = $urandom_range(1, 6);
            pbits  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
            start_frame();
            for (int k = 0; k < nbytes; k++) begin
                b = 8'($urandom_range(0, 255));
                send_bits(b, 8);
                model_push(b);
            end
            if (pbits != 0) begin
                send_bits(8'($urandom_range(0, 255)), pbits);
                exp_ferr = 1'b1;
            end
            end_frame();
            check($sformatf("rnd%0d_count", it), 32'(fifo_count), 32'(exp_q.size()));
            check($sformatf("rnd%0d_ovf", it),   32'(overflow),   32'(exp_ovf));
            check($sformatf("rnd%0d_ferr", it),  32'(frame_err),  32'(exp_ferr));
            drain($sformatf("rnd%0d", it));
            pulse_clr();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
